// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, reset constants and fetch state encodings for the IF stage.
// Pure declarations; no logic, no latency.
// Not applicable (no handshakes).
package if_fetch_ctrl_pkg;

    localparam int PcWidth           = 32;
    localparam int InstWidth         = 32;
    localparam int PcInstBusWidth    = PcWidth + InstWidth;
    localparam logic RstEnable       = 1'b1;
    localparam logic [PcWidth-1:0] IfFetchResetPc = 32'h1C00_0000;
    localparam int IfFetchStateWidth = 2;

    // REQ: request on the bus; WAIT: one request outstanding; HOLD: instruction buffered for ID.
    typedef enum logic [IfFetchStateWidth-1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_redirect_sel.sv
// Priority select of the pipeline redirect: exception beats branch.
// Purely combinational, zero latency.
// No backpressure; the consumer samples flush/target when it needs them.
module if_redirect_sel
    import if_fetch_ctrl_pkg::*;
#(
    parameter int PC_W = PcWidth
) (
    input  logic            branch_flush,
    input  logic [PC_W-1:0] branch_pc,
    input  logic            excep_flush,
    input  logic [PC_W-1:0] excep_pc,
    output logic            flush,
    output logic [PC_W-1:0] target
);

    // Either source redirects; the exception target has priority when both fire.
    always_comb begin
        flush  = branch_flush | excep_flush;
        target = excep_flush ? excep_pc : branch_pc;
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding SRAM-like request, one-entry return buffer toward IF/ID.
// Latency: valid toward ID rises the cycle after data_ok; the next request issues the cycle after ID takes it.
// Backpressure: id_allowin_i=0 holds the buffered {pc,inst} and suppresses new requests until it is taken.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int              PC_W     = PcWidth,
    parameter int              INST_W   = InstWidth,
    parameter logic [PC_W-1:0] RESET_PC = IfFetchResetPc
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   branch_flush_i,
    input  logic [PC_W-1:0]        branch_pc_i,
    input  logic                   excep_flush_i,
    input  logic [PC_W-1:0]        excep_pc_i,
    input  logic                   id_allowin_i,
    output logic                   inst_sram_req_o,
    output logic [PC_W-1:0]        inst_sram_addr_o,
    input  logic                   inst_sram_addr_ok_i,
    input  logic                   inst_sram_data_ok_i,
    input  logic [INST_W-1:0]      inst_sram_rdata_i,
    output logic                   if_to_id_valid_o,
    output logic [PC_W+INST_W-1:0] pc_inst_obus
);

    fetch_state_e             state, state_nxt;
    logic [PC_W-1:0]          fetch_pc, fetch_pc_nxt;
    logic [PC_W-1:0]          req_pc, req_pc_nxt;
    logic                     discard, discard_nxt;
    logic [PC_W+INST_W-1:0]   pc_inst_buf, pc_inst_buf_nxt;
    logic                     valid_q, valid_nxt;
    logic                     flush;
    logic [PC_W-1:0]          target;
    logic                     in_rst;

    assign in_rst = (rst_n == RstEnable);

    if_redirect_sel #(
        .PC_W (PC_W)
    ) u_redirect_sel (
        .branch_flush (branch_flush_i),
        .branch_pc    (branch_pc_i),
        .excep_flush  (excep_flush_i),
        .excep_pc     (excep_pc_i),
        .flush        (flush),
        .target       (target)
    );

    // Next-state: advance the fetch transaction and apply redirects.
    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        req_pc_nxt      = req_pc;
        discard_nxt     = discard;
        pc_inst_buf_nxt = pc_inst_buf;
        valid_nxt       = valid_q;
        case (state)
            REQ: begin
                if (inst_sram_addr_ok_i) begin
                    // Accepted with the address already on the bus, even if a flush coincides.
                    req_pc_nxt   = fetch_pc;
                    state_nxt    = WAIT;
                    discard_nxt  = flush;
                    fetch_pc_nxt = flush ? target : fetch_pc + PC_W'(4);
                end else if (flush) begin
                    fetch_pc_nxt = target;
                end
            end
            WAIT: begin
                if (inst_sram_data_ok_i) begin
                    state_nxt   = REQ;
                    discard_nxt = 1'b0;
                    if (flush) begin
                        // Response lands on the flush cycle: drop it here, no later discard needed.
                        fetch_pc_nxt = target;
                    end else if (!discard) begin
                        pc_inst_buf_nxt = {req_pc, inst_sram_rdata_i};
                        valid_nxt       = 1'b1;
                        state_nxt       = HOLD;
                    end
                end else if (flush) begin
                    discard_nxt  = 1'b1;
                    fetch_pc_nxt = target;
                end
            end
            HOLD: begin
                if (flush) begin
                    valid_nxt       = 1'b0;
                    pc_inst_buf_nxt = '0;
                    fetch_pc_nxt    = target;
                    state_nxt       = REQ;
                end else if (id_allowin_i) begin
                    valid_nxt = 1'b0;
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (in_rst) begin
            state       <= REQ;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            discard     <= 1'b0;
            pc_inst_buf <= '0;
            valid_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            req_pc      <= req_pc_nxt;
            discard     <= discard_nxt;
            pc_inst_buf <= pc_inst_buf_nxt;
            valid_q     <= valid_nxt;
        end
    end

    // Request only in REQ and never while reset is held.
    assign inst_sram_req_o  = (state == REQ) && !in_rst;
    assign inst_sram_addr_o = fetch_pc;
    assign if_to_id_valid_o = valid_q;
    assign pc_inst_obus     = pc_inst_buf;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_flush_i, excep_flush_i, id_allowin_i;
    logic [31:0] branch_pc_i, excep_pc_i;
    logic        inst_sram_req_o;
    logic [31:0] inst_sram_addr_o;
    logic        inst_sram_addr_ok_i, inst_sram_data_ok_i;
    logic [31:0] inst_sram_rdata_i;
    logic        if_to_id_valid_o;
    logic [63:0] pc_inst_obus;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch_flush_i      (branch_flush_i),
        .branch_pc_i         (branch_pc_i),
        .excep_flush_i       (excep_flush_i),
        .excep_pc_i          (excep_pc_i),
        .id_allowin_i        (id_allowin_i),
        .inst_sram_req_o     (inst_sram_req_o),
        .inst_sram_addr_o    (inst_sram_addr_o),
        .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
        .inst_sram_data_ok_i (inst_sram_data_ok_i),
        .inst_sram_rdata_i   (inst_sram_rdata_i),
        .if_to_id_valid_o    (if_to_id_valid_o),
        .pc_inst_obus        (pc_inst_obus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: next address, an in-flight request (maybe doomed), a held instruction.
    logic        m_init = 1'b0;
    logic [31:0] m_pc;
    logic        m_inflight, m_drop, m_have, m_obus_zero;
    logic [31:0] m_inflight_pc;
    logic [63:0] m_held;

    always @(posedge clk) begin
        logic        fl;
        logic [31:0] tg;
        fl = branch_flush_i | excep_flush_i;
        tg = excep_flush_i ? excep_pc_i : branch_pc_i;
        if (rst_n) begin
            m_init = 1'b1; m_pc = RST_PC; m_inflight = 1'b0; m_drop = 1'b0;
            m_have = 1'b0; m_obus_zero = 1'b1; m_inflight_pc = '0; m_held = '0;
        end else if (m_init) begin
            if (m_have) begin
                if (fl) begin m_have = 1'b0; m_pc = tg; end
                else if (id_allowin_i) m_have = 1'b0;
            end else if (m_inflight) begin
                if (inst_sram_data_ok_i) begin
                    if (!m_drop && !fl) begin
                        m_have = 1'b1; m_obus_zero = 1'b0;
                        m_held = {m_inflight_pc, inst_sram_rdata_i};
                    end
                    if (fl) m_pc = tg;
                    m_inflight = 1'b0; m_drop = 1'b0;
                end else if (fl) begin
                    m_drop = 1'b1; m_pc = tg;
                end
            end else begin
                if (inst_sram_addr_ok_i) begin
                    m_inflight = 1'b1; m_inflight_pc = m_pc; m_drop = fl;
                    m_pc = fl ? tg : m_pc + 32'd4;
                end else if (fl) m_pc = tg;
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            logic exp_req;
            exp_req = !rst_n && !m_inflight && !m_have;
            check("cmp_req", {63'd0, inst_sram_req_o}, {63'd0, exp_req});
            if (exp_req) check("cmp_addr", {32'd0, inst_sram_addr_o}, {32'd0, m_pc});
            check("cmp_valid", {63'd0, if_to_id_valid_o}, {63'd0, m_have});
            if (m_have) check("cmp_obus", pc_inst_obus, m_held);
            else if (m_obus_zero) check("cmp_obus_zero", pc_inst_obus, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        branch_flush_i = 0; excep_flush_i = 0; id_allowin_i = 0;
        inst_sram_addr_ok_i = 0; inst_sram_data_ok_i = 0;
    endtask

    // From REQ: accept, return data next cycle, hold for `hold` cycles, then hand to ID.
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] rd, input int hold);
        inst_sram_addr_ok_i = 1;
        @(negedge clk);
        check("dir_valid_low", {63'd0, if_to_id_valid_o}, 64'd0);
        check("dir_req", {63'd0, inst_sram_req_o}, 64'd1);
        check("dir_addr", {32'd0, inst_sram_addr_o}, {32'd0, exp_addr});
        tick(); inst_sram_addr_ok_i = 0;
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = rd;
        @(negedge clk);
        check("dir_wait_noreq", {63'd0, inst_sram_req_o}, 64'd0);
        tick(); inst_sram_data_ok_i = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("dir_hold_valid", {63'd0, if_to_id_valid_o}, 64'd1);
            check("dir_hold_obus", pc_inst_obus, {exp_addr, rd});
            check("dir_hold_noreq", {63'd0, inst_sram_req_o}, 64'd0);
            tick();
        end
        id_allowin_i = 1;
        @(negedge clk);
        check("dir_out_valid", {63'd0, if_to_id_valid_o}, 64'd1);
        check("dir_out_obus", pc_inst_obus, {exp_addr, rd});
        tick(); id_allowin_i = 0;
    endtask

    initial begin
        rst_n = 1; clear_in();
        branch_pc_i = '0; excep_pc_i = '0; inst_sram_rdata_i = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_req", {63'd0, inst_sram_req_o}, 64'd0);
        check("rst_valid", {63'd0, if_to_id_valid_o}, 64'd0);
        check("rst_obus", pc_inst_obus, 64'd0);
        tick(); rst_n = 0;

        // Request sits one cycle unaccepted, then two back-to-back fetches.
        @(negedge clk);
        check("first_req", {63'd0, inst_sram_req_o}, 64'd1);
        check("first_addr", {32'd0, inst_sram_addr_o}, 64'h1C00_0000);
        tick();
        fetch_one(32'h1C00_0000, 32'hA000_0001, 0);
        fetch_one(32'h1C00_0004, 32'hA000_0002, 0);
        // ID stalls five cycles.
        fetch_one(32'h1C00_0008, 32'hA000_0003, 5);

        // Branch flush in WAIT; the late response is dropped.
        inst_sram_addr_ok_i = 1;
        @(negedge clk);
        check("wf_addr", {32'd0, inst_sram_addr_o}, 64'h1C00_000C);
        tick(); inst_sram_addr_ok_i = 0;
        branch_flush_i = 1; branch_pc_i = 32'h1C00_0100;
        tick(); branch_flush_i = 0;
        tick(); tick();
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'hDEAD_BEEF;
        tick(); inst_sram_data_ok_i = 0;
        @(negedge clk);
        check("wf_valid", {63'd0, if_to_id_valid_o}, 64'd0);
        check("wf_req", {63'd0, inst_sram_req_o}, 64'd1);
        check("wf_addr_tgt", {32'd0, inst_sram_addr_o}, 64'h1C00_0100);

        // Both flushes in HOLD; exception target wins and overrides allowin.
        tick();
        inst_sram_addr_ok_i = 1; tick(); inst_sram_addr_ok_i = 0;
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h1111_2222; tick(); inst_sram_data_ok_i = 0;
        @(negedge clk);
        check("hf_valid_before", {63'd0, if_to_id_valid_o}, 64'd1);
        tick();
        branch_flush_i = 1; branch_pc_i = 32'h1C00_0100;
        excep_flush_i = 1; excep_pc_i = 32'h1C00_8000; id_allowin_i = 1;
        tick(); clear_in();
        @(negedge clk);
        check("hf_valid", {63'd0, if_to_id_valid_o}, 64'd0);
        check("hf_addr", {32'd0, inst_sram_addr_o}, 64'h1C00_8000);

        // Flush coincident with data_ok; the next response must be accepted.
        tick();
        inst_sram_addr_ok_i = 1; tick(); inst_sram_addr_ok_i = 0;
        inst_sram_data_ok_i = 1; inst_sram_rdata_i = 32'h3333_4444;
        branch_flush_i = 1; branch_pc_i = 32'h1C00_0200;
        tick(); clear_in();
        @(negedge clk);
        check("cf_valid", {63'd0, if_to_id_valid_o}, 64'd0);
        check("cf_addr", {32'd0, inst_sram_addr_o}, 64'h1C00_0200);
        tick();
        fetch_one(32'h1C00_0200, 32'h5555_6666, 0);

        // Address wrap at the top of the space.
        branch_flush_i = 1; branch_pc_i = 32'hFFFF_FFFC;
        tick(); branch_flush_i = 0;
        fetch_one(32'hFFFF_FFFC, 32'h7777_8888, 0);
        fetch_one(32'h0000_0000, 32'h9999_AAAA, 0);
        check("model_pc_wrap", {32'd0, m_pc}, 64'h0000_0004);

        // Randomized traffic, including spurious handshakes and mid-flight resets.
        for (int c = 0; c < 4000; c++) begin
            logic exp_req;
            rst_n = ($urandom_range(0, 299) == 0);
            exp_req = !m_inflight && !m_have;
            branch_flush_i = ($urandom_range(0, 11) == 0);
            excep_flush_i  = ($urandom_range(0, 19) == 0);
            branch_pc_i = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            excep_pc_i  = {$urandom_range(0, 65535), 16'h0};
            id_allowin_i = ($urandom_range(0, 2) != 0);
            inst_sram_addr_ok_i = exp_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            inst_sram_data_ok_i = m_inflight ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 14) == 0);
            inst_sram_rdata_i = $urandom;
            tick();
        end
        rst_n = 0; clear_in();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
